// File: rtl/icf3z_pkg.sv
// Shared opcodes, instruction field positions, interrupt vectors and FSM states for icf3z_core.
package icf3z_pkg;

  localparam int unsigned InstrW = 30;
  localparam int unsigned OpLsb  = 25;
  localparam int unsigned RdLsb  = 21;
  localparam int unsigned RsLsb  = 17;

  localparam logic [4:0] OpNop     = 5'h00;
  localparam logic [4:0] OpLoadK   = 5'h01;
  localparam logic [4:0] OpLoadR   = 5'h02;
  localparam logic [4:0] OpAddK    = 5'h03;
  localparam logic [4:0] OpAdd     = 5'h04;
  localparam logic [4:0] OpAddc    = 5'h05;
  localparam logic [4:0] OpSub     = 5'h06;
  localparam logic [4:0] OpSubc    = 5'h07;
  localparam logic [4:0] OpAnd     = 5'h08;
  localparam logic [4:0] OpOr      = 5'h09;
  localparam logic [4:0] OpXor     = 5'h0A;
  localparam logic [4:0] OpCmp     = 5'h0B;
  localparam logic [4:0] OpSubK    = 5'h0C;
  localparam logic [4:0] OpSr0     = 5'h0D;
  localparam logic [4:0] OpSl0     = 5'h0E;
  localparam logic [4:0] OpRr      = 5'h0F;
  localparam logic [4:0] OpInput   = 5'h10;
  localparam logic [4:0] OpOutput  = 5'h11;
  localparam logic [4:0] OpOutputK = 5'h12;
  localparam logic [4:0] OpJump    = 5'h13;
  localparam logic [4:0] OpJumpZ   = 5'h14;
  localparam logic [4:0] OpJumpNz  = 5'h15;
  localparam logic [4:0] OpJumpC   = 5'h16;
  localparam logic [4:0] OpJumpNc  = 5'h17;
  localparam logic [4:0] OpCall    = 5'h18;
  localparam logic [4:0] OpReturn  = 5'h19;
  localparam logic [4:0] OpReturnI = 5'h1A;
  localparam logic [4:0] OpEint    = 5'h1B;
  localparam logic [4:0] OpDint    = 5'h1C;
  localparam logic [4:0] OpHalt    = 5'h1F;

  localparam int unsigned VecInt0 = 'h3F0;
  localparam int unsigned VecInt1 = 'h3F8;

  typedef enum logic [1:0] {StFetch, StExec, StIor, StHalt} state_e;

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op >= OpAddK) && (op <= OpRr);
  endfunction

endpackage

// File: rtl/icf3z_alu.sv
// Combinational 8-bit ALU: arithmetic (carry = carry-out or borrow), logic, shifts and rotate.
module icf3z_alu
  import icf3z_pkg::*;
(
  input  logic [4:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] result,
  output logic       cout,
  output logic       zero
);

  logic [8:0] sum;

  always_comb begin
    sum    = 9'h000;
    result = a;
    cout   = cin;
    case (op)
      OpAddK, OpAdd: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[7:0];
        cout   = sum[8];
      end
      OpAddc: begin
        sum    = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        result = sum[7:0];
        cout   = sum[8];
      end
      // Bit 8 of the 9-bit difference is the borrow.
      OpSub, OpSubK, OpCmp: begin
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[7:0];
        cout   = sum[8];
      end
      OpSubc: begin
        sum    = {1'b0, a} - {1'b0, b} - {8'h00, cin};
        result = sum[7:0];
        cout   = sum[8];
      end
      OpAnd: begin
        result = a & b;
        cout   = 1'b0;
      end
      OpOr: begin
        result = a | b;
        cout   = 1'b0;
      end
      OpXor: begin
        result = a ^ b;
        cout   = 1'b0;
      end
      OpSr0: begin
        result = {1'b0, a[7:1]};
        cout   = a[0];
      end
      OpSl0: begin
        result = {a[6:0], 1'b0};
        cout   = a[7];
      end
      OpRr: begin
        result = {a[0], a[7:1]};
        cout   = a[0];
      end
      default: ;
    endcase
  end

  assign zero = (result == 8'h00);

endmodule

// File: rtl/icf3z_core.sv
// PicoBlaze-style 8-bit core: ROM fetch, 16x8 register file, call stack, port-addressed I/O.
// Interrupt support is built only when ICF3Z_INT_EN is defined.
module icf3z_core
  import icf3z_pkg::*;
#(
  parameter string       PROG_FILE   = "prog.hex",
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic       CLK,
  input  logic       xRESET_P,
  input  logic [7:0] xINPORT_P,
  input  logic       xINT0_P,
  input  logic       xINT1_P,
  output logic [7:0] xPORTID_P,
  output logic [7:0] xOUTPORT_P,
  output logic       xWSTROBE_P,
  output logic       xWSTROBEK_P,
  output logic       xIOSTROBE_P,
  output logic       xRSTROBE_P
);

`ifdef ICF3Z_INT_EN
  localparam bit IntEn = 1'b1;
`else
  localparam bit IntEn = 1'b0;
`endif

  localparam int unsigned SpW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] Vec0 = ADDR_W'(VecInt0);
  localparam logic [ADDR_W-1:0] Vec1 = ADDR_W'(VecInt1);

  logic [InstrW-1:0] rom [2**ADDR_W];

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [InstrW-1:0]   ir_q;
  logic                cf_q, zf_q, ie_q;
  logic [1:0]          pend_q, int_prev_q;
  logic [SpW-1:0]      sp_q;
  // Stack entry: {cf, zf, pc}; flags are only restored by RETURNI.
  logic [ADDR_W+1:0]   stack_q [STACK_DEPTH];
  logic [7:0]          rf [16];
  logic [7:0]          port_q, outport_q;
  logic                wstb_q, wstbk_q, iostb_q, rstb_q;

  logic [4:0]          op;
  logic [3:0]          rd, rs;
  logic [7:0]          k, rd_val, rs_val, alu_b, alu_res;
  logic [ADDR_W-1:0]   tgt;
  logic                alu_c, alu_z, take_jump;
  logic [SpW-1:0]      sp_inc, sp_dec;
  logic [ADDR_W+1:0]   pop_entry;
  logic [1:0]          int_edge, pend_clr, pend_nxt;
  logic                int_take;
  logic                rf_we;
  logic [7:0]          rf_wd;
  logic                unused_bits;

  assign op          = ir_q[OpLsb +: 5];
  assign rd          = ir_q[RdLsb +: 4];
  assign rs          = ir_q[RsLsb +: 4];
  assign k           = ir_q[7:0];
  assign tgt         = ir_q[ADDR_W-1:0];
  assign unused_bits = ^ir_q[16:10];

  assign rd_val = rf[rd];
  assign rs_val = rf[rs];
  assign alu_b  = (op == OpAddK || op == OpSubK) ? k : rs_val;

  icf3z_alu u_alu (
    .op     (op),
    .a      (rd_val),
    .b      (alu_b),
    .cin    (cf_q),
    .result (alu_res),
    .cout   (alu_c),
    .zero   (alu_z)
  );

  assign sp_inc    = (sp_q == SpW'(STACK_DEPTH - 1)) ? '0 : sp_q + SpW'(1);
  assign sp_dec    = (sp_q == '0) ? SpW'(STACK_DEPTH - 1) : sp_q - SpW'(1);
  assign pop_entry = stack_q[sp_dec];

  always_comb begin
    take_jump = 1'b0;
    case (op)
      OpJump:   take_jump = 1'b1;
      OpJumpZ:  take_jump = zf_q;
      OpJumpNz: take_jump = ~zf_q;
      OpJumpC:  take_jump = cf_q;
      OpJumpNc: take_jump = ~cf_q;
      default:  ;
    endcase
  end

  // Level inputs become one-shot requests: only a low-to-high transition sets pending.
  assign int_edge = {xINT1_P, xINT0_P} & ~int_prev_q;
  assign int_take = IntEn && ie_q && (pend_q != 2'b00) && (state_q == StFetch);
  assign pend_clr = !int_take ? 2'b00 : (pend_q[0] ? 2'b01 : 2'b10);
  assign pend_nxt = IntEn ? ((pend_q | int_edge) & ~pend_clr) : 2'b00;

  always_ff @(posedge CLK) begin
    int_prev_q <= {xINT1_P, xINT0_P};
  end

  always_comb begin
    rf_we = 1'b0;
    rf_wd = alu_res;
    if (state_q == StIor) begin
      rf_we = 1'b1;
      rf_wd = xINPORT_P;
    end else if (state_q == StExec) begin
      if (op == OpLoadK) begin
        rf_we = 1'b1;
        rf_wd = k;
      end else if (op == OpLoadR) begin
        rf_we = 1'b1;
        rf_wd = rs_val;
      end else if (is_alu_op(op) && op != OpCmp) begin
        rf_we = 1'b1;
      end
    end
    rf_we = rf_we & xRESET_P;
  end

  always_ff @(posedge CLK) begin
    if (rf_we) rf[rd] <= rf_wd;
  end

  always_ff @(posedge CLK) begin
    if (!xRESET_P) begin
      state_q   <= StFetch;
      pc_q      <= '0;
      ir_q      <= '0;
      sp_q      <= '0;
      cf_q      <= 1'b0;
      zf_q      <= 1'b0;
      ie_q      <= 1'b0;
      pend_q    <= 2'b00;
      port_q    <= 8'h00;
      outport_q <= 8'h00;
      wstb_q    <= 1'b0;
      wstbk_q   <= 1'b0;
      iostb_q   <= 1'b0;
      rstb_q    <= 1'b0;
    end else begin
      wstb_q  <= 1'b0;
      wstbk_q <= 1'b0;
      iostb_q <= 1'b0;
      rstb_q  <= 1'b0;
      pend_q  <= pend_nxt;
      unique case (state_q)
        StFetch: begin
          if (int_take) begin
            stack_q[sp_q] <= {cf_q, zf_q, pc_q};
            sp_q          <= sp_inc;
            ie_q          <= 1'b0;
            pc_q          <= pend_q[0] ? Vec0 : Vec1;
          end else begin
            ir_q    <= rom[pc_q];
            pc_q    <= pc_q + ADDR_W'(1);
            state_q <= StExec;
          end
        end
        StExec: begin
          state_q <= StFetch;
          if (is_alu_op(op)) begin
            cf_q <= alu_c;
            zf_q <= alu_z;
          end
          case (op)
            OpInput: begin
              port_q  <= k;
              rstb_q  <= 1'b1;
              iostb_q <= 1'b1;
              state_q <= StIor;
            end
            OpOutput: begin
              port_q    <= k;
              outport_q <= rd_val;
              wstb_q    <= 1'b1;
              iostb_q   <= 1'b1;
            end
            OpOutputK: begin
              port_q    <= {4'h0, rs};
              outport_q <= k;
              wstbk_q   <= 1'b1;
              iostb_q   <= 1'b1;
            end
            OpJump, OpJumpZ, OpJumpNz, OpJumpC, OpJumpNc: begin
              if (take_jump) pc_q <= tgt;
            end
            OpCall: begin
              stack_q[sp_q] <= {cf_q, zf_q, pc_q};
              sp_q          <= sp_inc;
              pc_q          <= tgt;
            end
            OpReturn, OpReturnI: begin
              pc_q <= pop_entry[ADDR_W-1:0];
              sp_q <= sp_dec;
              if (IntEn && op == OpReturnI) begin
                cf_q <= pop_entry[ADDR_W+1];
                zf_q <= pop_entry[ADDR_W];
                ie_q <= 1'b1;
              end
            end
            OpEint: if (IntEn) ie_q <= 1'b1;
            OpDint: if (IntEn) ie_q <= 1'b0;
            OpHalt: state_q <= StHalt;
            default: ;
          endcase
        end
        StIor:  state_q <= StFetch;
        StHalt: ;
      endcase
    end
  end

  assign xPORTID_P   = port_q;
  assign xOUTPORT_P  = outport_q;
  assign xWSTROBE_P  = wstb_q;
  assign xWSTROBEK_P = wstbk_q;
  assign xIOSTROBE_P = iostb_q;
  assign xRSTROBE_P  = rstb_q;

endmodule

// File: tb/tb_icf3z_core.sv
// Directed bench for icf3z_core: programs are written into the ROM image, results observed on
// the I/O bus and selected internal state. Interrupt expectations follow ICF3Z_INT_EN.
module tb_icf3z_core;
  import icf3z_pkg::*;

  // Opcodes written out independently of the design package.
  localparam logic [4:0] ONop = 5'h00, OLdK = 5'h01, OAddK = 5'h03, OAddc = 5'h05;
  localparam logic [4:0] OSub = 5'h06, OSubc = 5'h07, OAnd = 5'h08, OOr = 5'h09;
  localparam logic [4:0] OXor = 5'h0A, OCmp = 5'h0B, OSubK = 5'h0C, OSr0 = 5'h0D;
  localparam logic [4:0] OSl0 = 5'h0E, ORr = 5'h0F, OIn = 5'h10, OOut = 5'h11;
  localparam logic [4:0] OOutK = 5'h12, OJmp = 5'h13, OJz = 5'h14, OJnz = 5'h15;
  localparam logic [4:0] OJc = 5'h16, OJnc = 5'h17, OCall = 5'h18, ORet = 5'h19;
  localparam logic [4:0] ORetI = 5'h1A, OEint = 5'h1B, OHalt = 5'h1F;

  logic       clk = 1'b0;
  logic       xRESET_P = 1'b0;
  logic [7:0] xINPORT_P = 8'h00;
  logic       xINT0_P = 1'b0, xINT1_P = 1'b0;
  logic [7:0] xPORTID_P, xOUTPORT_P;
  logic       xWSTROBE_P, xWSTROBEK_P, xIOSTROBE_P, xRSTROBE_P;

  always #5 clk = ~clk;

  icf3z_core #(.PROG_FILE(""), .ADDR_W(10), .STACK_DEPTH(8)) dut (
    .CLK         (clk),
    .xRESET_P    (xRESET_P),
    .xINPORT_P   (xINPORT_P),
    .xINT0_P     (xINT0_P),
    .xINT1_P     (xINT1_P),
    .xPORTID_P   (xPORTID_P),
    .xOUTPORT_P  (xOUTPORT_P),
    .xWSTROBE_P  (xWSTROBE_P),
    .xWSTROBEK_P (xWSTROBEK_P),
    .xIOSTROBE_P (xIOSTROBE_P),
    .xRSTROBE_P  (xRSTROBE_P)
  );

  int n_cmp = 0, n_bad = 0, io_bad = 0, wp = 0;
  logic [29:0] img [1024];
  logic [17:0] wq [$];
  logic [15:0] kq [$];
  logic [7:0]  rq [$];
  logic [15:0] exp_k [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] enc(input logic [4:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [9:0] low);
    return {op, rd, rs, 7'b0, low};
  endfunction

  task automatic emit(input logic [29:0] w);
    img[wp] = w;
    wp++;
  endtask
  task automatic ik(input logic [4:0] op, input logic [3:0] rd, input logic [7:0] k);
    emit(enc(op, rd, 4'h0, {2'b00, k}));
  endtask
  task automatic irr(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs);
    emit(enc(op, rd, rs, 10'h000));
  endtask
  task automatic ia(input logic [4:0] op, input logic [9:0] a);
    emit(enc(op, 4'h0, 4'h0, a));
  endtask
  task automatic outk(input logic [7:0] k, input logic [3:0] p);
    emit(enc(OOutK, 4'h0, p, {2'b00, k}));
  endtask

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = 30'h0;
    wp = 0;
  endtask

  task automatic start_run();
    xRESET_P = 1'b0;
    for (int i = 0; i < 1024; i++) dut.rom[i] = img[i];
    repeat (2) @(negedge clk);
    wq.delete();
    kq.delete();
    rq.delete();
    xRESET_P = 1'b1;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    logic halted;
    halted = 1'b0;
    for (int i = 0; i < budget && !halted; i++) begin
      @(negedge clk);
      halted = (dut.state_q == StHalt);
    end
    check_eq(tag, {31'b0, halted}, 32'd1);
  endtask

  task automatic cmp_trace(input string tag);
    check_eq({tag, "_len"}, kq.size(), exp_k.size());
    for (int i = 0; i < kq.size() && i < exp_k.size(); i++)
      check_eq($sformatf("%s_%0d", tag, i), {16'h0, kq[i]}, {16'h0, exp_k[i]});
  endtask

  always @(negedge clk) begin
    if (xRESET_P) begin
      if (xWSTROBE_P) wq.push_back({dut.cf_q, dut.zf_q, xPORTID_P, xOUTPORT_P});
      if (xWSTROBEK_P) kq.push_back({xPORTID_P, xOUTPORT_P});
      if (xRSTROBE_P) rq.push_back(xPORTID_P);
      if (xIOSTROBE_P !== (xWSTROBE_P | xWSTROBEK_P | xRSTROBE_P)) io_bad++;
    end
  end

  logic [17:0] exp_w [13];

  initial begin
    // Load/halt program plus reset state.
    clear_img();
    ik(OLdK, 4'd7, 8'd12);
    ik(OLdK, 4'd8, 8'd34);
    ik(OLdK, 4'd9, 8'd56);
    ik(OLdK, 4'd10, 8'd78);
    ia(OHalt, 10'h0);
    start_run();
    check_eq("rst_pc", {22'b0, dut.pc_q}, 32'd0);
    check_eq("rst_ir", {2'b0, dut.ir_q}, 32'd0);
    check_eq("rst_flags", {30'b0, dut.cf_q, dut.zf_q}, 32'd0);
    check_eq("rst_outs", {12'b0, xPORTID_P, xOUTPORT_P, xWSTROBE_P, xWSTROBEK_P,
                          xIOSTROBE_P, xRSTROBE_P}, 32'd0);
    wait_halt("t1_halt", 50);
    check_eq("t1_r7", {24'b0, dut.rf[7]}, 32'd12);
    check_eq("t1_r8", {24'b0, dut.rf[8]}, 32'd34);
    check_eq("t1_r9", {24'b0, dut.rf[9]}, 32'd56);
    check_eq("t1_r10", {24'b0, dut.rf[10]}, 32'd78);
    repeat (10) @(negedge clk);
    check_eq("t1_ir_op", {27'b0, dut.ir_q[29:25]}, 32'h1F);
    check_eq("t1_pc_stuck", {22'b0, dut.pc_q}, 32'd5);
    check_eq("t1_still_halt", {31'b0, dut.state_q == StHalt}, 32'd1);

    // INPUT then OUTPUT.
    clear_img();
    ik(OIn, 4'd1, 8'h20);
    ik(OOut, 4'd1, 8'h40);
    ia(OHalt, 10'h0);
    xINPORT_P = 8'h5E;
    start_run();
    wait_halt("t2_halt", 50);
    check_eq("t2_rd_cnt", rq.size(), 32'd1);
    if (rq.size() > 0) check_eq("t2_rd_port", {24'b0, rq[0]}, 32'h20);
    check_eq("t2_r1", {24'b0, dut.rf[1]}, 32'h5E);
    check_eq("t2_wr_cnt", wq.size(), 32'd1);
    if (wq.size() > 0) check_eq("t2_wr", {16'b0, wq[0][15:0]}, 32'h405E);
    check_eq("t2_hold", {16'b0, xPORTID_P, xOUTPORT_P}, 32'h405E);
    xINPORT_P = 8'h00;

    // ALU results and flags, each observed through an OUTPUT: {cf, zf, port, data}.
    clear_img();
    ik(OLdK, 4'd3, 8'h00);   ik(OLdK, 4'd0, 8'hFF);
    ik(OAddK, 4'd0, 8'h01);  ik(OOut, 4'd0, 8'h01);
    irr(OAddc, 4'd0, 4'd3);  ik(OOut, 4'd0, 8'h02);
    ik(OLdK, 4'd4, 8'h00);   ik(OLdK, 4'd5, 8'h01);
    irr(OSub, 4'd4, 4'd5);   ik(OOut, 4'd4, 8'h03);
    ik(OLdK, 4'd6, 8'hA5);   ik(OLdK, 4'd7, 8'h0F);
    irr(OAnd, 4'd6, 4'd7);   ik(OOut, 4'd6, 8'h04);
    irr(OXor, 4'd6, 4'd6);   ik(OOut, 4'd6, 8'h05);
    ik(OLdK, 4'd8, 8'h81);   irr(OSr0, 4'd8, 4'd0); ik(OOut, 4'd8, 8'h06);
    irr(ORr, 4'd8, 4'd0);    ik(OOut, 4'd8, 8'h07);
    ik(OLdK, 4'd9, 8'h10);   irr(OCmp, 4'd9, 4'd5); ik(OOut, 4'd9, 8'h08);
    ik(OLdK, 4'd10, 8'h80);  irr(OSl0, 4'd10, 4'd0); ik(OOut, 4'd10, 8'h09);
    ik(OLdK, 4'd11, 8'h05);  irr(OSubc, 4'd11, 4'd5); ik(OOut, 4'd11, 8'h0B);
    ik(OSubK, 4'd11, 8'h04); ik(OOut, 4'd11, 8'h0C);
    irr(OOr, 4'd11, 4'd5);   ik(OOut, 4'd11, 8'h0D);
    ik(OLdK, 4'd12, 8'h01);  irr(ORr, 4'd12, 4'd0); ik(OOut, 4'd12, 8'h0E);
    ia(OHalt, 10'h0);
    exp_w = '{{2'b11, 8'h01, 8'h00}, {2'b00, 8'h02, 8'h01}, {2'b10, 8'h03, 8'hFF},
              {2'b00, 8'h04, 8'h05}, {2'b01, 8'h05, 8'h00}, {2'b10, 8'h06, 8'h40},
              {2'b00, 8'h07, 8'h20}, {2'b00, 8'h08, 8'h10}, {2'b11, 8'h09, 8'h00},
              {2'b00, 8'h0B, 8'h03}, {2'b10, 8'h0C, 8'hFF}, {2'b00, 8'h0D, 8'hFF},
              {2'b10, 8'h0E, 8'h80}};
    start_run();
    wait_halt("t3_halt", 200);
    check_eq("t3_len", wq.size(), 32'd13);
    for (int i = 0; i < 13 && i < wq.size(); i++)
      check_eq($sformatf("t3_alu_%0d", i), {14'b0, wq[i]}, {14'b0, exp_w[i]});

    // Nested calls and conditional jumps, traced with OUTPUTK markers.
    clear_img();
    ia(OCall, 10'h20);      outk(8'h01, 4'h0);   ik(OLdK, 4'd1, 8'h00);
    ik(OAddK, 4'd1, 8'h00); ia(OJnz, 10'h30);    ia(OJz, 10'd7);
    outk(8'hEE, 4'h0);      outk(8'h02, 4'h0);   ia(OJnc, 10'd10);
    outk(8'hEE, 4'h0);      ia(OJc, 10'h30);     outk(8'h03, 4'h0);
    ik(OSubK, 4'd1, 8'h01); ia(OJz, 10'h30);     ia(OJc, 10'd16);
    outk(8'hEE, 4'h0);      ia(OJnz, 10'd18);    outk(8'hEE, 4'h0);
    ia(OJnc, 10'h30);       outk(8'h04, 4'h0);   ia(OHalt, 10'h0);
    wp = 'h20; outk(8'hA1, 4'h5); ia(OCall, 10'h24); outk(8'hA2, 4'h0); ia(ORet, 10'h0);
    wp = 'h24; outk(8'hB1, 4'h0); ia(OCall, 10'h28); outk(8'hB2, 4'h0); ia(ORet, 10'h0);
    wp = 'h28; outk(8'hC1, 4'h0); ia(ORetI, 10'h0);
    wp = 'h30; outk(8'hEE, 4'h0); ia(OHalt, 10'h0);
    exp_k = '{16'h05A1, 16'h00B1, 16'h00C1, 16'h00B2, 16'h00A2,
              16'h0001, 16'h0002, 16'h0003, 16'h0004};
    start_run();
    wait_halt("t4_halt", 300);
    cmp_trace("t4_trace");

    // INT0 pulse during a NOP sled; handler clobbers flags, RETURNI must restore C=1,Z=1.
    clear_img();
    ia(OEint, 10'h0); ik(OLdK, 4'd0, 8'hFF); ik(OAddK, 4'd0, 8'h01);
    wp = 200; ia(OJnc, 10'h100); ia(OJnz, 10'h100); outk(8'h77, 4'h0); ia(OHalt, 10'h0);
    wp = 'h100; outk(8'hEE, 4'h0); ia(OHalt, 10'h0);
    wp = 'h3F0; outk(8'h90, 4'h0); ik(OLdK, 4'd5, 8'h01); ik(OAddK, 4'd5, 8'h01);
    ia(ORetI, 10'h0);
    wp = 'h3F8; outk(8'h91, 4'h0); ia(ORetI, 10'h0);
`ifdef ICF3Z_INT_EN
    exp_k = '{16'h0090, 16'h0077};
`else
    exp_k = '{16'h0077};
`endif
    start_run();
    repeat (100) @(negedge clk);
    xINT0_P = 1'b1;
    repeat (3) @(negedge clk);
    xINT0_P = 1'b0;
    wait_halt("t5_halt", 1000);
    cmp_trace("t5_trace");
`ifdef ICF3Z_INT_EN
    check_eq("t5_ie", {31'b0, dut.ie_q}, 32'd1);
`else
    check_eq("t5_ie", {31'b0, dut.ie_q}, 32'd0);
`endif

    // INT1 held high through reset: no rising edge, so no interrupt.
    xINT1_P = 1'b1;
    exp_k = '{16'h0077};
    start_run();
    wait_halt("t6_halt", 1000);
    cmp_trace("t6_trace");
    xINT1_P = 1'b0;

    check_eq("io_strobe_or", io_bad, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
